// File: rtl/clk_ratio_meter.sv
// Measures the period of clk_in in clk cycles, detects lock after LOCK_CNT equal periods, and flags period changes and timeouts.
// Optional macro DUTY_CHECK_EN adds high-time capture and a duty_err pulse; without it, duty_err is tied low.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for the first rising edge; no period reported
// MEASURE | first edge seen, timing the first full period
// TRACK   | periods reported, counting consecutive equal periods
// LOCKED  | LOCK_CNT equal periods seen; a changed period drops lock
module clk_ratio_meter #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             duty_err
);

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  state_t           state;
  logic             clk_in_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ref_per;
  logic [3:0]       match_cnt;
  logic [3:0]       match_nxt;
  logic             rise;
  logic             sat;
  logic             same;

  assign rise      = clk_in & ~clk_in_q;
  assign sat       = (cnt == CNT_MAX);
  assign same      = (cnt == ref_per);
  assign match_nxt = match_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      clk_in_q     <= 1'b0;
      cnt          <= '0;
      ref_per      <= '0;
      match_cnt    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      clk_in_q     <= clk_in;
      period_valid <= 1'b0;
      err          <= 1'b0;

      if (rise)
        cnt <= CNT_ONE;
      else if (!sat)
        cnt <= cnt + CNT_ONE;

      // A rise always wins over saturation, so a period of exactly CNT_MAX is reported, not timed out.
      case (state)
        IDLE: begin
          if (rise)
            state <= MEASURE;
        end
        MEASURE: begin
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            ref_per      <= cnt;
            match_cnt    <= 4'd1;
            state        <= TRACK;
          end else if (sat) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        TRACK: begin
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (same) begin
              match_cnt <= match_nxt;
              if (match_nxt == LOCK_TGT) begin
                locked <= 1'b1;
                state  <= LOCKED;
              end
            end else begin
              ref_per   <= cnt;
              match_cnt <= 4'd1;
            end
          end else if (sat) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (rise) begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (!same) begin
              err       <= 1'b1;
              locked    <= 1'b0;
              ref_per   <= cnt;
              match_cnt <= 4'd1;
              state     <= TRACK;
            end
          end else if (sat) begin
            err    <= 1'b1;
            locked <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUTY_CHECK_EN
  logic             fall;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] high_cap;
  logic [CNT_W-1:0] half_lo;
  logic [CNT_W-1:0] half_hi;
  logic             duty_bad;

  assign fall     = ~clk_in & clk_in_q;
  assign half_lo  = cnt >> 1;
  assign half_hi  = half_lo + {{(CNT_W-1){1'b0}}, cnt[0]};
  assign duty_bad = (high_cap != half_lo) && (high_cap != half_hi);

  // The first period after IDLE is reported from MEASURE and is deliberately not checked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      high_cnt <= '0;
      high_cap <= '0;
      duty_err <= 1'b0;
    end else begin
      if (rise)
        high_cnt <= CNT_ONE;
      else if (clk_in_q && (high_cnt != CNT_MAX))
        high_cnt <= high_cnt + CNT_ONE;
      if (fall)
        high_cap <= high_cnt;
      duty_err <= rise && ((state == TRACK) || (state == LOCKED)) && duty_bad;
    end
  end
`else
  assign duty_err = 1'b0;
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter: lock, period change, timeout, saturation, reset and duty behaviour.
// Duty expectations follow DUTY_CHECK_EN when the macro is defined for the build.
module tb_clk_ratio_meter;

  logic       clk;
  logic       reset;
  logic       clk_in;
  logic [7:0] period;
  logic       period_valid;
  logic       locked;
  logic       err;
  logic       duty_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  int pv_per[$];
  int pv_lk[$];
  int pv_err[$];
  int pv_duty[$];
  int pv_cyc[$];
  int err_cnt = 0;
  int err_cyc = 0;
  int duty_cnt = 0;

  clk_ratio_meter #(.CNT_W(8), .LOCK_CNT(4)) dut (
    .clk(clk),
    .reset(reset),
    .clk_in(clk_in),
    .period(period),
    .period_valid(period_valid),
    .locked(locked),
    .err(err),
    .duty_err(duty_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (period_valid) begin
      pv_per.push_back(int'(period));
      pv_lk.push_back(int'(locked));
      pv_err.push_back(int'(err));
      pv_duty.push_back(int'(duty_err));
      pv_cyc.push_back(cyc);
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (duty_err) duty_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    pv_per.delete();
    pv_lk.delete();
    pv_err.delete();
    pv_duty.delete();
    pv_cyc.delete();
    err_cnt = 0;
    duty_cnt = 0;
  endtask

  task automatic do_reset();
    clk_in = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  task automatic wave(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < per; c++) begin
        clk_in = (c < hi);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_duty;
    int waited;
    reset  = 1'b0;
    clk_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_period", int'(period), 0);
    chk("rst_pv", int'(period_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_duty", int'(duty_err), 0);

    // divide-by-2: 8 rises -> 7 periods of 2, lock at the 5th rise
    do_reset();
    wave(2, 1, 8);
    chk("div2_pv_count", pv_per.size(), 7);
    for (int i = 0; i < 7; i++) chk($sformatf("div2_per%0d", i), pv_per[i], 2);
    chk("div2_lk_before", pv_lk[2], 0);
    chk("div2_lk_5th", pv_lk[3], 1);
    chk("div2_lk_end", int'(locked), 1);
    chk("div2_err", err_cnt, 0);

    // divide-by-8, 50% duty
    do_reset();
    wave(8, 4, 6);
    chk("div8_pv_count", pv_per.size(), 5);
    chk("div8_per0", pv_per[0], 8);
    chk("div8_per4", pv_per[4], 8);
    chk("div8_lk_before", pv_lk[2], 0);
    chk("div8_lk_5th", pv_lk[3], 1);
    chk("div8_duty", duty_cnt, 0);
    chk("div8_err", err_cnt, 0);

    // locked at /4, switch to /8
    do_reset();
    wave(4, 2, 6);
    chk("sw_lk4", int'(locked), 1);
    clear_log();
    wave(8, 4, 6);
    chk("sw_pv_count", pv_per.size(), 6);
    chk("sw_per0", pv_per[0], 4);
    chk("sw_lk0", pv_lk[0], 1);
    chk("sw_per1", pv_per[1], 8);
    chk("sw_err1", pv_err[1], 1);
    chk("sw_lk1", pv_lk[1], 0);
    chk("sw_err_count", err_cnt, 1);
    chk("sw_lk3", pv_lk[3], 0);
    chk("sw_relock4", pv_lk[4], 1);
    chk("sw_per4", pv_per[4], 8);

    // timeout: locked at /4 then clk_in held low
    do_reset();
    wave(4, 2, 6);
    chk("to_lk", int'(locked), 1);
    clk_in = 1'b0;
    waited = 0;
    while (err_cnt == 0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("to_seen", int'(err_cnt != 0), 1);
    chk("to_delay", err_cyc - pv_cyc[pv_cyc.size()-1], 255);
    chk("to_locked", int'(locked), 0);
    chk("to_period", int'(period), 4);
    repeat (20) @(negedge clk);
    chk("to_err_once", err_cnt, 1);
    clear_log();
    wave(4, 2, 1);
    repeat (3) @(negedge clk);
    chk("to_idle_no_pv", pv_per.size(), 0);

    // period exactly at saturation is reported, one more cycle times out
    do_reset();
    wave(255, 1, 2);
    chk("sat_pv_count", pv_per.size(), 1);
    chk("sat_period", pv_per[0], 255);
    chk("sat_no_err", err_cnt, 0);
    do_reset();
    wave(256, 1, 2);
    chk("over_err", err_cnt, 1);
    chk("over_no_pv", pv_per.size(), 0);

    // constant high never yields a period
    do_reset();
    clk_in = 1'b1;
    repeat (300) @(negedge clk);
    chk("const_no_pv", pv_per.size(), 0);

    // reset while locked
    do_reset();
    wave(4, 2, 6);
    chk("rl_lk", int'(locked), 1);
    reset = 1'b0;
    clk_in = 1'b1;
    @(negedge clk);
    clk_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rl_period", int'(period), 0);
    chk("rl_locked", int'(locked), 0);
    chk("rl_pv", int'(period_valid), 0);
    chk("rl_err", int'(err), 0);
    reset = 1'b1;
    @(negedge clk);
    clear_log();
    wave(4, 2, 6);
    chk("rl_pv_count", pv_per.size(), 5);
    chk("rl_lk_before", pv_lk[2], 0);
    chk("rl_lk_5th", pv_lk[3], 1);
    chk("rl_per", pv_per[3], 4);

    // period 8, high 2
    do_reset();
    wave(8, 2, 5);
    chk("duty_pv_count", pv_per.size(), 4);
    for (int i = 0; i < 4; i++) begin
`ifdef DUTY_CHECK_EN
      exp_duty = (i > 0) ? 1 : 0;
`else
      exp_duty = 0;
`endif
      chk($sformatf("duty_pv%0d", i), pv_duty[i], exp_duty);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_ratio_meter.md
CLK_RATIO_METER -- requirements
Module: clk_ratio_meter

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of period counter and period output.
REQ-002 SHALL have parameter: LOCK_CNT, 4, consecutive equal periods required for lock (range 2..15).
REQ-003 SHALL have port: clk  input  1  single system clock; all logic on posedge clk.
REQ-004 SHALL have port: reset  input  1  one clock; reset is synchronous and active-low.
REQ-005 SHALL have port: clk_in  input  1  divided clock under measurement, derived synchronously from clk.
REQ-006 SHALL have port: period  output  CNT_W  last measured clk_in period in clk cycles.
REQ-007 SHALL have port: period_valid  output  1  one-cycle pulse when period updates.
REQ-008 SHALL have port: locked  output  1  level; LOCK_CNT consecutive equal periods seen.
REQ-009 SHALL have port: err  output  1  one-cycle pulse on loss of lock or timeout.
REQ-010 SHALL have port: duty_err  output  1  one-cycle pulse on bad duty cycle (see Configuration).

Function
REQ-011 SHALL register clk_in each cycle into clk_in_q; rise = clk_in & ~clk_in_q; fall = ~clk_in & clk_in_q.
REQ-012 SHALL run cycle counter cnt: on rise load 1, else increment, saturating at 2^CNT_W-1.
REQ-013 SHALL implement FSM states IDLE, MEASURE, TRACK, LOCKED; reset state IDLE.
REQ-014 IDLE: on rise -> MEASURE; no period output.
REQ-015 MEASURE: on rise, period<=cnt, ref<=cnt, match_cnt<=1, period_valid pulse next cycle, -> TRACK.
REQ-016 TRACK: on rise, period<=cnt and period_valid pulse; if cnt==ref then match_cnt++, else ref<=cnt, match_cnt<=1.
REQ-017 TRACK: when match_cnt reaches LOCK_CNT -> LOCKED; locked asserts the same cycle as that period_valid.
REQ-018 LOCKED: on rise with cnt==ref, period_valid pulse, stay; with cnt!=ref, period_valid and err pulse same cycle, locked deasserts, ref<=cnt, match_cnt<=1, -> TRACK.
REQ-019 Timeout: in MEASURE, TRACK or LOCKED, cnt reaching saturation without rise SHALL pulse err once, deassert locked, -> IDLE; period holds last value.
REQ-020 Divide-by-2 input (clk_in toggles every cycle) SHALL measure period=2; divide-by-1 or constant clk_in SHALL never produce period_valid.
REQ-021 Output latency: period/period_valid/locked/err update on the clk edge following the cycle rise is detected.
REQ-022 Simultaneous rise and saturation SHALL be treated as rise (period = saturated value, no timeout err).

Reset
REQ-023 On reset=0 at posedge clk: state=IDLE, cnt=0, clk_in_q=0, ref=0, match_cnt=0, period=0, period_valid=0, locked=0, err=0, duty_err=0.
REQ-024 Reset asserted mid-measurement SHALL discard partial count; first rise after release only re-enters MEASURE.

Configuration
REQ-025 Macro DUTY_CHECK_EN defined: SHALL count high-time cycles (load 1 on rise, increment while clk_in_q high, capture on fall) and pulse duty_err with period_valid when captured high time is neither floor(period/2) nor ceil(period/2); no check on first period after IDLE.
REQ-026 Macro DUTY_CHECK_EN undefined: high-time logic SHALL be absent and duty_err tied 0; all other behaviour identical.

Verification
REQ-027 Divide-by-2 after reset release, LOCK_CNT=4 -> period=2 on every period_valid; locked=1 at 5th rise; err never pulses.
REQ-028 Divide-by-8, 50% duty -> period=8, locked after 5 rises; with DUTY_CHECK_EN, duty_err stays 0.
REQ-029 Divide-by-4 locked, switch to divide-by-8 -> one period_valid with period=6 or 8 plus err pulse, locked=0, relock after 4 equal periods of 8.
REQ-030 Locked at divide-by-4, hold clk_in low -> err pulse 255 cycles after last rise (CNT_W=8), locked=0, state IDLE, period stays 4.
REQ-031 With DUTY_CHECK_EN, clk_in period 8 high 2 -> duty_err pulse with each period_valid from second period onward.
REQ-032 Assert reset for 3 cycles while locked at divide-by-4 -> all outputs 0 next cycle; after release locked again at 5th rise.
